// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// Ownership lasts for a whole cyc; a watchdog terminates stalled strobes with err.
module wb_rr_arbiter #(
  parameter int         NUM_MASTERS = 2,
  parameter logic [7:0] TIMEOUT     = 8'd255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_lock_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    gnt_o,
  output logic                      timeout_o
);

  localparam int IW = (NUM_MASTERS > 2) ? 2 : 1;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic                   state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_owner_q, last_owner_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [7:0]             wd_cnt_q, wd_cnt_d;
  logic                   timeout_q, timeout_d;

  logic [IW-1:0] cand;
  logic [IW-1:0] winner;
  logic          found;
  logic          own_cyc;
  logic          stb_raw;
  logic          term;
  logic          wd_fire;

  // Search upward from the previous owner so every requester gets a turn.
  always_comb begin
    cand   = '0;
    winner = last_owner_q;
    found  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IW'((int'(last_owner_q) + i) % NUM_MASTERS);
      if (!found && m_cyc_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    own_cyc = 1'b0;
    stb_raw = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (state_q == ST_BUSY && owner_q == IW'(k)) begin
        s_adr_o = m_adr_i[32*k +: 32];
        s_dat_o = m_dat_i[32*k +: 32];
        s_sel_o = m_sel_i[4*k +: 4];
        s_we_o  = m_we_i[k];
        own_cyc = m_cyc_i[k];
        stb_raw = m_stb_i[k];
      end
    end
  end

  // A genuine slave termination on the same cycle always beats the watchdog.
  assign term     = s_ack_i | s_err_i | s_rty_i;
  assign wd_fire  = (TIMEOUT != 8'd0) && (wd_cnt_q == TIMEOUT - 8'd1) && stb_raw && !term;
  assign s_cyc_o  = own_cyc;
  assign s_stb_o  = stb_raw & ~wd_fire;
  assign s_lock_o = 1'b0;
  assign m_dat_o  = s_dat_i;
  assign gnt_o    = gnt_q;
  assign timeout_o = timeout_q;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (state_q == ST_BUSY && owner_q == IW'(k)) begin
        m_ack_o[k] = s_ack_i & s_stb_o;
        m_rty_o[k] = s_rty_i & s_stb_o;
        m_err_o[k] = (s_err_i & s_stb_o) | wd_fire;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    wd_cnt_d     = (!s_stb_o || term) ? 8'd0 : wd_cnt_q + 8'd1;
    timeout_d    = wd_fire;
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d       = ST_BUSY;
        owner_d       = winner;
        gnt_d         = '0;
        gnt_d[winner] = 1'b1;
      end
    end else if (!own_cyc) begin
      state_d      = ST_IDLE;
      gnt_d        = '0;
      last_owner_d = owner_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_MASTERS - 1);
      gnt_q        <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter with two masters and an 8-cycle watchdog.
// Expected master responses are queued as the slave side is driven and popped as they appear.
module tb_wb_rr_arbiter;

  localparam int NM = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*NM-1:0] m_adr_i;
  logic [32*NM-1:0] m_dat_i;
  logic [4*NM-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_lock_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;
  logic [NM-1:0]    gnt_o;
  logic             timeout_o;

  typedef struct {
    logic [5:0]  resp;
    logic [31:0] dat;
    bit          chk_dat;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  wb_rr_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(8'd8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_lock_o(s_lock_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NM-1:0] cyc, input logic [NM-1:0] stb, input logic [NM-1:0] we);
    m_cyc_i = cyc;
    m_stb_i = stb;
    m_we_i  = we;
  endtask

  task automatic push_resp(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat, input bit chk);
    exp_t e;
    e.resp    = {ack, err, 2'b00};
    e.dat     = dat;
    e.chk_dat = chk;
    sb_q.push_back(e);
  endtask

  // Any nonzero response toward the masters must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (m_ack_o | m_err_o | m_rty_o) != '0) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_resp", {58'd0, m_ack_o, m_err_o, m_rty_o}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("resp", {58'd0, m_ack_o, m_err_o, m_rty_o}, {58'd0, e.resp});
        if (e.chk_dat) checkOutput("rdata", {32'd0, m_dat_o}, {32'd0, e.dat});
      end
    end
  end

  initial begin : guard
    #1000000;
    $display("[TB] FAIL global_timeout: got hang, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b1;
    m_adr_i = {32'h2000_0000, 32'h1000_0000};
    m_dat_i = '0;
    m_sel_i = 8'hF3;
    applyStimulus('0, '0, '0);
    s_dat_i = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gnt", {62'd0, gnt_o}, 64'd0);
    checkOutput("rst_cyc", {63'd0, s_cyc_o}, 64'd0);
    checkOutput("rst_stb", {63'd0, s_stb_o}, 64'd0);
    checkOutput("rst_timeout", {63'd0, timeout_o}, 64'd0);
    checkOutput("rst_adr", {32'd0, s_adr_o}, 64'd0);
    rst = 1'b0;

    // Single read by master 0, slave acks on the third owned cycle.
    step();
    applyStimulus(2'b01, 2'b01, 2'b00);
    @(negedge clk);
    checkOutput("a_cyc_latency", {63'd0, s_cyc_o}, 64'd0);
    step();
    @(negedge clk);
    checkOutput("a_cyc", {63'd0, s_cyc_o}, 64'd1);
    checkOutput("a_gnt", {62'd0, gnt_o}, 64'd1);
    checkOutput("a_adr", {32'd0, s_adr_o}, 64'h1000_0000);
    checkOutput("a_lock", {63'd0, s_lock_o}, 64'd0);
    step();
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEADBEEF;
    push_resp(2'b01, 2'b00, 32'hDEADBEEF, 1'b1);
    step();
    s_ack_i = 1'b0;
    s_dat_i = '0;
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    @(negedge clk);
    checkOutput("a_release_gnt", {62'd0, gnt_o}, 64'd0);

    // Simultaneous requests from reset: master 0 first, then master 1, then master 0 again.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(2'b11, 2'b11, 2'b00);
    step();
    @(negedge clk);
    checkOutput("b_first", {62'd0, gnt_o}, 64'd1);
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1111_1111;
    push_resp(2'b01, 2'b00, 32'h1111_1111, 1'b1);
    step();
    s_ack_i = 1'b0;
    applyStimulus(2'b10, 2'b10, 2'b00);
    step();
    @(negedge clk);
    checkOutput("b_idle_gap", {62'd0, gnt_o}, 64'd0);
    step();
    @(negedge clk);
    checkOutput("b_second", {62'd0, gnt_o}, 64'd2);
    checkOutput("b_adr", {32'd0, s_adr_o}, 64'h2000_0000);
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'h2222_2222;
    push_resp(2'b10, 2'b00, 32'h2222_2222, 1'b1);
    step();
    s_ack_i = 1'b0;
    applyStimulus(2'b01, 2'b01, 2'b00);
    step();
    @(negedge clk);
    checkOutput("b_idle2", {62'd0, gnt_o}, 64'd0);
    applyStimulus(2'b11, 2'b11, 2'b00);
    step();
    @(negedge clk);
    checkOutput("b_rr_back", {62'd0, gnt_o}, 64'd1);
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    step();

    // Master 1 block write of four beats while master 0 waits.
    applyStimulus(2'b10, 2'b00, 2'b10);
    step();
    @(negedge clk);
    checkOutput("c_grant", {62'd0, gnt_o}, 64'd2);
    applyStimulus(2'b11, 2'b00, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      m_dat_i[63:32] = 32'hA000_0000 + 32'(i);
      applyStimulus(2'b11, 2'b10, 2'b10);
      @(negedge clk);
      checkOutput("c_wdata", {32'd0, s_dat_o}, {32'd0, 32'hA000_0000 + 32'(i)});
      checkOutput("c_we", {63'd0, s_we_o}, 64'd1);
      checkOutput("c_sel", {60'd0, s_sel_o}, 64'hF);
      step();
      s_ack_i = 1'b1;
      push_resp(2'b10, 2'b00, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("c_gnt_hold", {62'd0, gnt_o}, 64'd2);
      step();
      s_ack_i = 1'b0;
      applyStimulus(2'b11, 2'b00, 2'b10);
      @(negedge clk);
      checkOutput("c_gnt_gap", {62'd0, gnt_o}, 64'd2);
    end
    step();
    applyStimulus(2'b01, 2'b01, 2'b00);
    step();
    @(negedge clk);
    checkOutput("c_idle", {62'd0, gnt_o}, 64'd0);
    step();
    @(negedge clk);
    checkOutput("c_m0_after", {62'd0, gnt_o}, 64'd1);
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    step();

    // Master 1 strobes into a silent slave: watchdog fires on the 8th strobe cycle.
    applyStimulus(2'b10, 2'b10, 2'b00);
    step();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checkOutput("d_stb_pre", {63'd0, s_stb_o}, 64'd1);
      step();
    end
    push_resp(2'b00, 2'b10, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("d_fire_stb", {63'd0, s_stb_o}, 64'd0);
    checkOutput("d_fire_cyc", {63'd0, s_cyc_o}, 64'd1);
    checkOutput("d_fire_tmo", {63'd0, timeout_o}, 64'd0);
    step();
    @(negedge clk);
    checkOutput("d_tmo_pulse", {63'd0, timeout_o}, 64'd1);
    checkOutput("d_cyc_kept", {63'd0, s_cyc_o}, 64'd1);
    checkOutput("d_gnt_kept", {62'd0, gnt_o}, 64'd2);
    step();
    @(negedge clk);
    checkOutput("d_tmo_once", {63'd0, timeout_o}, 64'd0);
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    step();

    // Slave ack arrives exactly when the watchdog would fire: ack wins.
    applyStimulus(2'b01, 2'b01, 2'b00);
    step();
    repeat (7) step();
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFEF00D;
    push_resp(2'b01, 2'b00, 32'hCAFEF00D, 1'b1);
    @(negedge clk);
    checkOutput("e_no_err", {62'd0, m_err_o}, 64'd0);
    step();
    s_ack_i = 1'b0;
    @(negedge clk);
    checkOutput("e_no_timeout", {63'd0, timeout_o}, 64'd0);
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    step();

    // Asynchronous reset in the middle of a master 1 cycle.
    applyStimulus(2'b10, 2'b10, 2'b00);
    step();
    @(negedge clk);
    checkOutput("f_grant", {62'd0, gnt_o}, 64'd2);
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("f_rst_cyc", {63'd0, s_cyc_o}, 64'd0);
    checkOutput("f_rst_stb", {63'd0, s_stb_o}, 64'd0);
    checkOutput("f_rst_gnt", {62'd0, gnt_o}, 64'd0);
    applyStimulus(2'b11, 2'b11, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("f_post_rst_m0", {62'd0, gnt_o}, 64'd1);
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    step();

    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone slave port between NUM_MASTERS Wishbone masters, e.g. the serial debug master and the logic-analyzer capture DMA.
- Uses round-robin grant with bus ownership held for the whole cyc.
- A watchdog ends stalled cycles with err, so a dead slave cannot hang the serial debug path.
- Sits between the masters and the shared interconnect, on the same clock as both.

Parameters:
- NUM_MASTERS, 2, number of requesters; legal values 2..4.
- TIMEOUT, 8'd255, number of stb-high cycles without termination before the watchdog fires. 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock; everything is on posedge.
- rst_i  in  1  asynchronous active-high reset.
- m_adr_i  in  32*NUM_MASTERS  master addresses; master k uses bits [32k+31:32k].
- m_dat_i  in  32*NUM_MASTERS  master write data.
- m_sel_i  in  4*NUM_MASTERS  master byte selects.
- m_we_i  in  NUM_MASTERS  master write enables.
- m_cyc_i  in  NUM_MASTERS  master cycle requests.
- m_stb_i  in  NUM_MASTERS  master strobes.
- m_dat_o  out  32  slave read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master err.
- m_rty_o  out  NUM_MASTERS  per-master rty.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_lock_o  out  1  tied 0.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_rty_i  in  1  slave rty.
- gnt_o  out  NUM_MASTERS  registered one-hot grant.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, gnt_o=0, last_owner=NUM_MASTERS-1 so master 0 wins first, watchdog=0, timeout_o=0. All s_* control outputs and all m_ack_o/m_err_o/m_rty_o are 0 while in reset.
- Reset mid-transfer: the cycle is dropped immediately with no termination to the master.
- States: IDLE, BUSY.
- IDLE, no m_cyc_i set: stay in IDLE.
- IDLE, any m_cyc_i set: pick the first requester searching upward from last_owner+1, wrapping modulo NUM_MASTERS.
  - On the next edge: gnt_o = one-hot(winner), owner = winner, state = BUSY.
  - Grant latency is 1 cycle from m_cyc_i to s_cyc_o.
- BUSY: owner's m_cyc_i is 0 → on the next edge gnt_o=0, last_owner=owner, state=IDLE.
  - There is exactly one idle cycle between consecutive owners.
  - Another master's cyc never preempts the current owner.
- Outputs to the slave (combinational from owner and gnt_o):
  - s_adr_o, s_dat_o, s_sel_o and s_we_o follow the owner's inputs.
  - s_cyc_o = BUSY & m_cyc_i[owner].
  - s_stb_o = BUSY & m_stb_i[owner] & !wd_fire.
  - In IDLE, s_adr_o/s_dat_o/s_sel_o/s_we_o are 0.
- Responses: m_ack_o[owner] = s_ack_i & s_stb_o, likewise for m_rty_o.
  - m_err_o[owner] = (s_err_i & s_stb_o) | wd_fire.
  - Non-owners always see 0 on ack/err/rty.
  - Slave responses arriving while s_stb_o=0 are discarded.
- Watchdog: 8-bit counter.
  - Clears when s_stb_o=0 or when any of s_ack_i/s_err_i/s_rty_i is set; otherwise increments.
  - wd_fire = (TIMEOUT!=0) & (counter==TIMEOUT-1) & s_stb_o & no termination.
  - On wd_fire:
    - s_stb_o is forced 0 for that cycle.
    - Owner gets m_err_o for that cycle only.
    - timeout_o pulses on the next edge.
    - The counter clears.
    - Grant is kept; the master decides whether to drop cyc.
  - A real termination in the same cycle as wd_fire wins: the watchdog does not fire.
- Owner lowers stb while keeping cyc: the grant is held, covering block transfers and idle gaps within a cycle.
- Any m_cyc_i set in the same cycle the owner releases: it is arbitrated on the following IDLE cycle, with last_owner already updated.

Test Plan:
- Reset, then master 0 reads with slave ack after 3 cycles → s_cyc_o rises 1 cycle after m_cyc_i[0]; m_ack_o=2'b01 for 1 cycle; m_dat_o = s_dat_i = 32'hDEADBEEF.
- Masters 0 and 1 request together from reset → master 0 is granted first; after it drops cyc, one IDLE cycle, then gnt_o=2'b10. Both requesting again → master 0 next.
- Master 1 holds cyc over 4 strobed writes while master 0 requests → gnt_o stays 2'b10 through all 4 acks; master 0 is granted only after m_cyc_i[1] falls.
- TIMEOUT=8, slave never responds → m_err_o[owner]=1 and s_stb_o=0 on the 8th stb cycle; timeout_o pulses once; s_cyc_o stays 1 until the master drops cyc.
- Slave acks on the exact cycle the watchdog would fire → m_ack_o=1, m_err_o=0, timeout_o=0.
- rst_i asserted mid-transfer with no clock edge → s_cyc_o, s_stb_o and gnt_o go 0 immediately; after release, master 0 has priority.
